// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the pipeline control slice.
// Contents:
//   OPC_*         opcode[6:2] encodings seen by the hazard logic
//   hz_state_e    memory-wait FSM state encoding
//   reads_rs1/2   which source registers an instruction in D consumes
package rv_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_e;

    // U-type and JAL carry no rs1 field; everything else reads it.
    function automatic logic reads_rs1(input logic [4:0] op);
        return !((op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL));
    endfunction

    function automatic logic reads_rs2(input logic [4:0] op);
        return (op == OPC_BRANCH) || (op == OPC_STORE) || (op == OPC_OP);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low clear
//   inc    count one event this cycle
//   cnt    current count, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32I core.
// Produces the freeze / flush / load-use-stall strobes for every stage
// register, tracks memory wait episodes with a timeout FSM, defers branch
// flushes that arrive during a freeze, and keeps saturating event counters.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   D_op, D_rs1, D_rs2               decode-stage instruction fields
//   E_op, E_rd                       execute-stage register fields
//   jb                               branch/jump taken (resolved in E)
//   imem_ready, dmem_req, dmem_ready cache handshakes
//   waiting, flush, stall            stage-register control strobes
//   err                              sticky memory timeout
//   stall_cnt, flush_cnt, wait_cnt   saturating event counters
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       D_op,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic [4:0]       E_op,
    input  logic [4:0]       E_rd,
    input  logic             jb,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             waiting,
    output logic             flush,
    output logic             stall,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    import rv_pkg::*;

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] ONE_V     = TO_W'(1);

    hz_state_e       state_q;
    logic [TO_W-1:0] ep_cnt_q;
    logic [TO_W-1:0] ep_inc;
    logic            err_q;
    logic            jb_pend_q;
    logic            jb_pend_d;

    logic mem_busy;
    logic luh;

    // Combinational strobes (same-cycle response to the handshakes)
    assign mem_busy = ~imem_ready | (dmem_req & ~dmem_ready);

    // E_rd != 0 matters: a bubble in E also encodes as op 0 / rd 0.
    assign luh = (E_op == OPC_LOAD) && (E_rd != 5'd0) &&
                 (((E_rd == D_rs1) && reads_rs1(D_op)) ||
                  ((E_rd == D_rs2) && reads_rs2(D_op)));

    // Strobes are gated by rst_n so nothing leaks out while held in reset.
    assign waiting = rst_n & ((state_q == ST_ERR) | mem_busy);
    assign flush   = rst_n & (jb | jb_pend_q) & ~waiting;
    assign stall   = rst_n & luh & ~waiting & ~flush;

    // A taken branch seen during a freeze is remembered and replayed once;
    // a jb re-asserted in the replay cycle merges into the same flush.
    always_comb begin
        jb_pend_d = jb_pend_q;
        if (flush) begin
            jb_pend_d = 1'b0;
        end else if (jb && waiting) begin
            jb_pend_d = 1'b1;
        end
    end

    assign ep_inc = ep_cnt_q + ONE_V;

    // Registered state: wait-episode FSM and pending flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ep_cnt_q  <= '0;
            err_q     <= 1'b0;
            jb_pend_q <= 1'b0;
        end else begin
            jb_pend_q <= jb_pend_d;
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        ep_cnt_q <= ONE_V;
                        if (ONE_V == TIMEOUT_V) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mem_busy) begin
                        state_q  <= ST_RUN;
                        ep_cnt_q <= '0;
                    end else begin
                        ep_cnt_q <= ep_inc;
                        if (ep_inc == TIMEOUT_V) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    // Only reset leaves ERR.
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign err = err_q;

    // Event counters
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (waiting),
        .cnt   (wait_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with a small timeout and narrow
// counters so the error path and saturation are reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int CW  = 4;
    localparam int TO  = 8;
    localparam int TOW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    D_op = 5'b00100, D_rs1 = '0, D_rs2 = '0, E_op = 5'b00100, E_rd = '0;
    logic          jb = 1'b0, imem_ready = 1'b1, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic          waiting, flush, stall, err;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO), .TO_W(TOW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D_op       (D_op),
        .D_rs1      (D_rs1),
        .D_rs2      (D_rs2),
        .E_op       (E_op),
        .E_rd       (E_rd),
        .jb         (jb),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .waiting    (waiting),
        .flush      (flush),
        .stall      (stall),
        .err        (err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .wait_cnt   (wait_cnt)
    );

    typedef struct packed {
        logic          w;
        logic          f;
        logic          s;
        logic          e;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic [CW-1:0] wc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: counts of events, consecutive busy cycles.
    bit m_err, m_pend;
    int m_consec, m_sc, m_fc, m_wc;

    logic [4:0] ops [9] = '{5'b00000, 5'b01000, 5'b11000, 5'b01100, 5'b00100,
                            5'b01101, 5'b00101, 5'b11011, 5'b11001};

    function automatic bit ref_luh(input logic [4:0] dop, rs1, rs2, eop, erd);
        bit use1, use2;
        use1 = !(dop == 5'b01101 || dop == 5'b00101 || dop == 5'b11011);
        use2 = (dop == 5'b11000 || dop == 5'b01000 || dop == 5'b01100);
        return (eop == 5'b00000) && (erd != 0) &&
               ((use1 && erd == rs1) || (use2 && erd == rs2));
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic cyc(input logic r, input logic [4:0] dop, rs1, rs2, eop, erd,
                       input logic j, im, dq, dr);
        exp_t e;
        bit busy, w, f, s;
        @(posedge clk);
        #1;
        rst_n = r; D_op = dop; D_rs1 = rs1; D_rs2 = rs2; E_op = eop; E_rd = erd;
        jb = j; imem_ready = im; dmem_req = dq; dmem_ready = dr;
        if (!r) begin
            m_err = 0; m_pend = 0; m_consec = 0; m_sc = 0; m_fc = 0; m_wc = 0;
            e = '0;
        end else begin
            busy = !im || (dq && !dr);
            w = m_err || busy;
            f = (j || m_pend) && !w;
            s = ref_luh(dop, rs1, rs2, eop, erd) && !w && !f;
            e.w = w; e.f = f; e.s = s; e.e = m_err;
            e.sc = CW'(m_sc); e.fc = CW'(m_fc); e.wc = CW'(m_wc);
            if (f) m_pend = 0;
            else if (j && w) m_pend = 1;
            if (s) m_sc = sat_inc(m_sc);
            if (f) m_fc = sat_inc(m_fc);
            if (w) m_wc = sat_inc(m_wc);
            m_consec = busy ? m_consec + 1 : 0;
            if (m_consec >= TO) m_err = 1;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 1, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(0, 5'b00100, 0, 0, 5'b00100, 0, 0, 1, 0, 0);
    endtask

    // Monitor: one expected response per cycle, compared away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("waiting",   {31'd0, waiting}, {31'd0, e.w});
            chk("flush",     {31'd0, flush},   {31'd0, e.f});
            chk("stall",     {31'd0, stall},   {31'd0, e.s});
            chk("err",       {31'd0, err},     {31'd0, e.e});
            chk("stall_cnt", 32'(stall_cnt),   32'(e.sc));
            chk("flush_cnt", 32'(flush_cnt),   32'(e.fc));
            chk("wait_cnt",  32'(wait_cnt),    32'(e.wc));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2);
        // Load-use cases: OP reading rs2, rd==0 bubble, LUI, OP_IMM on rs1
        cyc(1, 5'b01100, 0, 5, 5'b00000, 5, 0, 1, 0, 0);
        cyc(1, 5'b01100, 0, 5, 5'b00000, 0, 0, 1, 0, 0);
        cyc(1, 5'b01101, 5, 0, 5'b00000, 5, 0, 1, 0, 0);
        cyc(1, 5'b00100, 7, 0, 5'b00000, 7, 0, 1, 0, 0);
        cyc(1, 5'b00100, 0, 7, 5'b00000, 7, 0, 1, 0, 0);
        idle(1);
        // Fetch freeze for four cycles
        for (int i = 0; i < 4; i++) cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
        idle(2);
        // Branch during a data-cache freeze is replayed once afterwards
        cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 1, 1, 1, 0);
        cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 1, 1, 0);
        cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 1, 1, 0);
        cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 1, 1, 1);
        idle(2);
        // Replay cycle with jb re-asserted gives a single flush
        cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 1, 0, 0, 0);
        cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 1, 1, 0, 0);
        idle(1);
        // Flush beats load-use
        cyc(1, 5'b01100, 0, 5, 5'b00000, 5, 1, 1, 0, 0);
        idle(1);
        // Counter saturation
        do_reset(1);
        for (int i = 0; i < 20; i++) cyc(1, 5'b01100, 0, 5, 5'b00000, 5, 0, 1, 0, 0);
        idle(2);
        // Timeout into ERR, stays frozen, cleared by reset mid-ERR
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 5'b01100, 0, 5, 5'b00000, 5, 1, 1, 0, 0);
        do_reset(1);
        idle(2);
        // Random traffic, two busy densities
        for (int p = 0; p < 2; p++) begin
            do_reset(1);
            for (int i = 0; i < 300; i++) begin
                cyc(($urandom_range(0, 63) != 0),
                    ops[$urandom_range(0, 8)],
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) != 0) ? 5'b00000 : ops[$urandom_range(0, 8)],
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0),
                    (p == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 3) != 0));
            end
        end
        idle(1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core with caches.
- Generates the three control strobes consumed by every stage register:
  - `waiting`: global freeze.
  - `flush`: drives each stage's `jb` input.
  - `stall`: load-use bubble.
- Inputs are the D/E-stage register fields and the I/D-cache ready handshakes.
- Tracks memory wait episodes with an FSM and timeout, holds branch flushes that arrive during a freeze, and keeps saturating performance counters.

Parameters:
- `CNT_W`, 32, width of each performance counter.
- `TIMEOUT`, 1023, wait cycles in one episode before entering ERR.
- `TO_W`, 10, width of the wait-episode counter; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `D_op`  in  5  opcode[6:2] of the instruction in D.
- `D_rs1`  in  5  rs1 field in D.
- `D_rs2`  in  5  rs2 field in D.
- `E_op`  in  5  opcode[6:2] held in the E register.
- `E_rd`  in  5  rd held in the E register.
- `jb`  in  1  branch/jump taken, resolved in E.
- `imem_ready`  in  1  I-cache delivers the fetch this cycle.
- `dmem_req`  in  1  M stage issues a load/store.
- `dmem_ready`  in  1  D-cache completes the M access this cycle.
- `waiting`  out  1  freeze all stage registers.
- `flush`  out  1  squash F/D and E (drives stage `jb`).
- `stall`  out  1  hold F/D, insert bubble into E.
- `err`  out  1  sticky memory timeout.
- `stall_cnt`  out  CNT_W  load-use stall cycles.
- `flush_cnt`  out  CNT_W  flushes issued.
- `wait_cnt`  out  CNT_W  frozen cycles.

Behaviour:
- Reset (`rst_n`=0, async): `state`=RUN, `jb_pending`=0, episode counter=0, `err`=0, all `*_cnt`=0. `waiting`, `flush` and `stall` are forced 0 while reset is asserted.
- `mem_busy` = !`imem_ready` | (`dmem_req` & !`dmem_ready`). This is combinational and has 0-cycle latency.
- FSM `state` values: RUN, WAIT, ERR.
  - RUN: `waiting`=`mem_busy`. If `mem_busy`, go to WAIT with episode count=1.
  - WAIT: `waiting`=`mem_busy`.
    - If !`mem_busy`, go to RUN and clear the episode count.
    - Otherwise increment the count. When count==`TIMEOUT`, go to ERR and set `err`=1.
  - ERR: `waiting`=1 permanently. Exit is by reset only.
- Load-use hazard `luh`, all conditions required:
  - `E_op`==LOAD (5'b00000) and `E_rd`!=0. The `rd`!=0 check is mandatory because a bubble also encodes op 0.
  - And either `E_rd`==`D_rs1` with D reading rs1, or `E_rd`==`D_rs2` with D reading rs2.
  - D reads rs1 unless `D_op` is LUI, AUIPC or JAL.
  - D reads rs2 only for BRANCH, STORE, OP.
- Priority, applied combinationally: `waiting` > `flush` > `stall`.
  - `flush` = (`jb` | `jb_pending`) & !`waiting`.
  - `stall` = `luh` & !`waiting` & !`flush`.
- `jb_pending`: set when `jb` & `waiting`; cleared on any cycle with `flush`=1. A `jb` arriving during a freeze therefore produces exactly one `flush`, in the first unfrozen cycle. A simultaneous re-asserted `jb` does not produce a second flush.
- Counters increment by 1 per cycle their strobe is 1: `stall_cnt` on `stall`, `flush_cnt` on `flush`, `wait_cnt` on `waiting`. They saturate at all-ones and never wrap.
- Mid-operation reset clears everything immediately, including any pending flush and ERR.

Decomposition:
- Shared package `rv_pkg` holds the opcode[6:2] constants (LOAD, STORE, BRANCH, OP, OP_IMM, LUI, AUIPC, JAL, JALR) and the FSM state encoding.
- One natural sub-module, `sat_counter` (parameter W, input `inc`, async active-low clear), instantiated three times.

Test Plan:
- Load-use: `E_op`=00000, `E_rd`=5, `D_op`=01100, `D_rs2`=5, all ready → `stall`=1, `flush`=0. Same with `E_rd`=0 → `stall`=0. With `D_op`=01101 (LUI), `D_rs1`=5 → `stall`=0.
- Freeze: `imem_ready`=0 for 4 cycles → `waiting`=1 in the same 4 cycles, `wait_cnt`=4, FSM back in RUN in cycle 5 with `waiting`=0.
- Deferred flush: `jb`=1 for one cycle while `dmem_req`=1 and `dmem_ready`=0 for 3 cycles → `flush`=0 during the freeze, `flush`=1 in exactly one cycle after `dmem_ready`, `flush_cnt`=1.
- Priority: `jb`=1 together with load-use `luh` and all ready → `flush`=1, `stall`=0, `stall_cnt` unchanged.
- Timeout with `TIMEOUT`=8: `imem_ready` held 0 → `err`=1 after cycle 8. `waiting` stays 1 after `imem_ready` returns. Asserting `rst_n`=0 mid-ERR → `err`=0 and all counters 0 immediately.
- Saturation with `CNT_W`=4: 20 stall cycles → `stall_cnt`=15 and it holds there.
